// File: rtl/xadac_vload_mem.sv
// Vector load memory responder: queues AR requests, issues Beats narrow reads each and returns the assembled vector on R.
// Define XADAC_VLOAD_MEM_OVERLAP_EN to add an output register so the next load's reads overlap a pending R.
module xadac_vload_mem #(
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned VecDataWidth = 256,
    parameter int unsigned MemDataWidth = 64,
    parameter int unsigned ArDepth      = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [IdWidth-1:0]      axi_ar_id,
    input  logic [AddrWidth-1:0]    axi_ar_addr,
    input  logic                    axi_ar_valid,
    output logic                    axi_ar_ready,
    output logic [IdWidth-1:0]      axi_r_id,
    output logic [VecDataWidth-1:0] axi_r_data,
    output logic                    axi_r_valid,
    input  logic                    axi_r_ready,
    output logic [AddrWidth-1:0]    mem_req_addr,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    input  logic [MemDataWidth-1:0] mem_rsp_data,
    input  logic                    mem_rsp_valid
);

    localparam int unsigned Beats     = VecDataWidth / MemDataWidth;
    localparam int unsigned CntW      = $clog2(Beats + 1);
    localparam int unsigned PtrW      = $clog2(ArDepth);
    localparam int unsigned CntFifoW  = PtrW + 1;
    localparam int unsigned AlignBits = $clog2(VecDataWidth / 8);
    localparam int unsigned BeatBytes = MemDataWidth / 8;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntFifoW-1:0]     count_q, count_d;
    logic [IdWidth-1:0]      fifo_id_q   [ArDepth];
    logic [IdWidth-1:0]      fifo_id_d   [ArDepth];
    logic [AddrWidth-1:0]    fifo_base_q [ArDepth];
    logic [AddrWidth-1:0]    fifo_base_d [ArDepth];
    logic [IdWidth-1:0]      id_q, id_d;
    logic [AddrWidth-1:0]    base_q, base_d;
    logic [CntW-1:0]         req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
    logic [VecDataWidth-1:0] asm_q, asm_d;
    logic                    push, pop, load, fifo_empty, fifo_full, req_hs, rsp_take;
    logic                    unused_addr_lsb;
`ifdef XADAC_VLOAD_MEM_OVERLAP_EN
    logic                    out_valid_q, out_valid_d;
    logic [IdWidth-1:0]      out_id_q, out_id_d;
    logic [VecDataWidth-1:0] out_data_q, out_data_d;
`endif

    // Addresses are stored pre-aligned, so the byte offset within a vector is dropped.
    assign unused_addr_lsb = ^axi_ar_addr[AlignBits-1:0];

    assign fifo_empty    = (count_q == '0);
    assign fifo_full     = (count_q == CntFifoW'(ArDepth));
    assign axi_ar_ready  = !fifo_full;
    assign push          = axi_ar_valid && axi_ar_ready;
    assign req_hs        = (state_q == REQ) && mem_req_ready;
    assign rsp_take      = mem_rsp_valid && ((state_q == REQ) || (state_q == WAIT))
                           && (rsp_cnt_q != CntW'(Beats));
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = base_q + AddrWidth'(req_cnt_q) * AddrWidth'(BeatBytes);

`ifdef XADAC_VLOAD_MEM_OVERLAP_EN
    assign axi_r_valid = out_valid_q;
    assign axi_r_id    = out_id_q;
    assign axi_r_data  = out_data_q;
`else
    assign axi_r_valid = (state_q == RESP);
    assign axi_r_id    = id_q;
    assign axi_r_data  = asm_q;
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_id_d   = fifo_id_q;
        fifo_base_d = fifo_base_q;
        id_d        = id_q;
        base_d      = base_q;
        req_cnt_d   = req_cnt_q;
        rsp_cnt_d   = rsp_cnt_q;
        asm_d       = asm_q;
        pop         = 1'b0;
        load        = 1'b0;
`ifdef XADAC_VLOAD_MEM_OVERLAP_EN
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        if (out_valid_q && axi_r_ready) out_valid_d = 1'b0;
`endif

        if (push) begin
            fifo_id_d[wr_ptr_q]   = axi_ar_id;
            fifo_base_d[wr_ptr_q] = {axi_ar_addr[AddrWidth-1:AlignBits], AlignBits'(0)};
            wr_ptr_d              = wr_ptr_q + PtrW'(1);
        end

        if (req_hs) req_cnt_d = req_cnt_q + CntW'(1);

        // Responses return in order, so the response count selects the destination slice.
        if (rsp_take) begin
            for (int unsigned b = 0; b < Beats; b++) begin
                if (rsp_cnt_q == CntW'(b)) asm_d[b*MemDataWidth +: MemDataWidth] = mem_rsp_data;
            end
            rsp_cnt_d = rsp_cnt_q + CntW'(1);
        end

        case (state_q)
            IDLE: load = !fifo_empty;
            REQ: begin
                if (req_hs && (req_cnt_q == CntW'(Beats - 1))) state_d = WAIT;
            end
            WAIT: begin
                if (rsp_cnt_d == CntW'(Beats)) begin
`ifdef XADAC_VLOAD_MEM_OVERLAP_EN
                    // Hand off only when the output slot is free or draining this cycle.
                    if (!out_valid_q || axi_r_ready) begin
                        out_valid_d = 1'b1;
                        out_id_d    = id_q;
                        out_data_d  = asm_d;
                        load        = !fifo_empty;
                        state_d     = IDLE;
                    end
`else
                    state_d = RESP;
`endif
                end
            end
            RESP: begin
                if (axi_r_valid && axi_r_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pop       = 1'b1;
            id_d      = fifo_id_q[rd_ptr_q];
            base_d    = fifo_base_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PtrW'(1);
            req_cnt_d = '0;
            rsp_cnt_d = '0;
            state_d   = REQ;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntFifoW'(1);
            2'b01:   count_d = count_q - CntFifoW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            id_q        <= '0;
            base_q      <= '0;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            asm_q       <= '0;
`ifdef XADAC_VLOAD_MEM_OVERLAP_EN
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            id_q        <= id_d;
            base_q      <= base_d;
            req_cnt_q   <= req_cnt_d;
            rsp_cnt_q   <= rsp_cnt_d;
            asm_q       <= asm_d;
`ifdef XADAC_VLOAD_MEM_OVERLAP_EN
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
`endif
        end
    end

    // Queue storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        fifo_id_q   <= fifo_id_d;
        fifo_base_q <= fifo_base_d;
    end

endmodule

// File: tb/tb_xadac_vload_mem.sv
// Self-checking bench for xadac_vload_mem: randomized AR traffic against an in-order memory model
// and a reference that rebuilds each expected vector from the aligned base address.
module tb_xadac_vload_mem;

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned VecW  = 256;
    localparam int unsigned MemW  = 64;
    localparam int unsigned Beats = VecW / MemW;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [IdW-1:0]   axi_ar_id = '0;
    logic [AddrW-1:0] axi_ar_addr = '0;
    logic             axi_ar_valid = 1'b0;
    logic             axi_ar_ready;
    logic [IdW-1:0]   axi_r_id;
    logic [VecW-1:0]  axi_r_data;
    logic             axi_r_valid;
    logic             axi_r_ready = 1'b0;
    logic [AddrW-1:0] mem_req_addr;
    logic             mem_req_valid;
    logic             mem_req_ready = 1'b1;
    logic [MemW-1:0]  mem_rsp_data = '0;
    logic             mem_rsp_valid = 1'b0;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned cyc     = 0;
    int unsigned lat_max = 1;
    int unsigned rdy_mode = 0;
    int unsigned last_due = 0;

    logic [MemW-1:0]  pend_data[$];
    int unsigned      pend_due[$];
    logic [AddrW-1:0] req_log[$];
    logic [IdW-1:0]   exp_id[$];
    logic [AddrW-1:0] exp_addr[$];

    xadac_vload_mem #(
        .IdWidth(IdW), .AddrWidth(AddrW), .VecDataWidth(VecW), .MemDataWidth(MemW), .ArDepth(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_valid(axi_ar_valid),
        .axi_ar_ready(axi_ar_ready),
        .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_valid(axi_r_valid),
        .axi_r_ready(axi_r_ready),
        .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_valid(mem_rsp_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [MemW-1:0] mem_word(input logic [AddrW-1:0] a);
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction

    function automatic logic [VecW-1:0] exp_vec(input logic [AddrW-1:0] a);
        logic [AddrW-1:0] base;
        logic [VecW-1:0]  v;
        base = a & ~AddrW'(VecW / 8 - 1);
        v = '0;
        for (int k = 0; k < int'(Beats); k++) v[k*MemW +: MemW] = mem_word(base + AddrW'(k * MemW / 8));
        return v;
    endfunction

    // In-order memory: accepts on valid&ready, answers after 1..lat_max cycles, one word per cycle.
    initial begin
        int unsigned due;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_data.size() > 0 && pend_due[0] <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = pend_data.pop_front();
                void'(pend_due.pop_front());
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
            end
            case (rdy_mode)
                0:       mem_req_ready = 1'b1;
                1:       mem_req_ready = ~mem_req_ready;
                default: mem_req_ready = 1'($urandom_range(0, 1));
            endcase
            if (mem_req_valid && mem_req_ready) begin
                due = cyc + $urandom_range(1, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_data.push_back(mem_word(mem_req_addr));
                pend_due.push_back(due);
                req_log.push_back(mem_req_addr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_send(input logic [IdW-1:0] id, input logic [AddrW-1:0] addr);
        int unsigned n = 0;
        axi_ar_id    = id;
        axi_ar_addr  = addr;
        axi_ar_valid = 1'b1;
        while (!axi_ar_ready && n < 200) begin
            tick();
            n++;
        end
        if (!axi_ar_ready) begin
            n_total++;
            $display("FAIL ar_timeout: axi_ar_ready=%b, required 1", axi_ar_ready);
        end else begin
            tick();
            exp_id.push_back(id);
            exp_addr.push_back(addr);
        end
        axi_ar_valid = 1'b0;
    endtask

    task automatic wait_r(output bit ok);
        int unsigned n = 0;
        while (!axi_r_valid && n < 300) begin
            tick();
            n++;
        end
        ok = axi_r_valid;
        if (!ok) begin
            n_total++;
            $display("FAIL r_timeout: axi_r_valid=%b, required 1", axi_r_valid);
        end
    endtask

    task automatic r_accept();
        axi_r_ready = 1'b1;
        tick();
        axi_r_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        n_total++; if (axi_ar_ready !== 1'b1) $display("FAIL rst_ar_ready: got %b, required 1", axi_ar_ready); else n_pass++;
        n_total++; if (axi_r_valid !== 1'b0) $display("FAIL rst_r_valid: got %b, required 0", axi_r_valid); else n_pass++;
        n_total++; if (axi_r_id !== '0) $display("FAIL rst_r_id: got %h, required 0", axi_r_id); else n_pass++;
        n_total++; if (axi_r_data !== '0) $display("FAIL rst_r_data: got %h, required 0", axi_r_data); else n_pass++;
        n_total++; if (mem_req_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b, required 0", mem_req_valid); else n_pass++;
        n_total++; if (mem_req_addr !== '0) $display("FAIL rst_mem_addr: got %h, required 0", mem_req_addr); else n_pass++;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        int unsigned k = 0;
        int unsigned bad = 0;
        bit ok;
        logic [AddrW-1:0] ea;
        rdy_mode = 0;
        lat_max  = 1;
        req_log.delete();
        ar_send(4'd3, 32'h1000);
        while (!axi_r_valid && k < 50) begin
            tick();
            k++;
            if (k == 1) begin
                n_total++;
                if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000)
                    $display("FAIL single_first_req: valid=%b addr=%h, required valid=1 addr=00001000", mem_req_valid, mem_req_addr);
                else n_pass++;
            end
        end
        n_total++; if (k != 6) $display("FAIL single_latency: got %0d cycles, required 6", k); else n_pass++;
        wait_r(ok);
        if (ok) begin
            ea = exp_addr.pop_front();
            void'(exp_id.pop_front());
            n_total++; if (axi_r_id !== 4'd3) $display("FAIL single_r_id: got %0d, required 3", axi_r_id); else n_pass++;
            n_total++; if (axi_r_data !== exp_vec(ea)) $display("FAIL single_r_data: got %h, required %h", axi_r_data, exp_vec(ea)); else n_pass++;
            r_accept();
        end
        for (int i = 0; i < int'(Beats); i++) begin
            if (req_log.size() != Beats || req_log[i] !== AddrW'(32'h1000 + i * 8)) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL single_addr_seq: %0d wrong of %0d logged, required 0 wrong", bad, req_log.size()); else n_pass++;
    endtask

    task automatic test_unaligned();
        bit ok;
        logic [IdW-1:0]   ei;
        logic [AddrW-1:0] ea;
        logic [AddrW-1:0] first;
        req_log.delete();
        ar_send(IdW'($urandom), 32'h101C);
        wait_r(ok);
        if (ok) begin
            ei = exp_id.pop_front();
            ea = exp_addr.pop_front();
            first = (req_log.size() > 0) ? req_log[0] : '1;
            n_total++; if (first !== 32'h1000) $display("FAIL unaligned_first_addr: got %h, required 00001000", first); else n_pass++;
            n_total++; if (axi_r_id !== ei) $display("FAIL unaligned_r_id: got %0d, required %0d", axi_r_id, ei); else n_pass++;
            n_total++; if (axi_r_data !== exp_vec(ea)) $display("FAIL unaligned_r_data: got %h, required %h", axi_r_data, exp_vec(ea)); else n_pass++;
            r_accept();
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [IdW-1:0]   ei;
        logic [AddrW-1:0] ea;
        axi_r_ready = 1'b0;
        ar_send(IdW'($urandom), AddrW'($urandom_range(0, 32'hFFFF)));
        ar_send(IdW'($urandom), AddrW'($urandom_range(0, 32'hFFFF)));
        for (int t = 0; t < 2; t++) begin
            wait_r(ok);
            if (ok) begin
                ei = exp_id.pop_front();
                ea = exp_addr.pop_front();
                n_total++; if (axi_r_id !== ei) $display("FAIL b2b_r_id%0d: got %0d, required %0d", t, axi_r_id, ei); else n_pass++;
                n_total++; if (axi_r_data !== exp_vec(ea)) $display("FAIL b2b_r_data%0d: got %h, required %h", t, axi_r_data, exp_vec(ea)); else n_pass++;
                r_accept();
`ifndef XADAC_VLOAD_MEM_OVERLAP_EN
                if (t == 0) begin
                    n_total++; if (mem_req_valid !== 1'b0) $display("FAIL b2b_idle_gap: mem_req_valid=%b, required 0", mem_req_valid); else n_pass++;
                    tick();
                    n_total++;
                    if (mem_req_valid !== 1'b1 || mem_req_addr !== (exp_addr[0] & ~AddrW'(31)))
                        $display("FAIL b2b_next_req: valid=%b addr=%h, required valid=1 addr=%h", mem_req_valid, mem_req_addr, exp_addr[0] & ~AddrW'(31));
                    else n_pass++;
                end
`endif
            end
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        logic [IdW-1:0]   ei;
        logic [AddrW-1:0] ea;
        axi_r_ready = 1'b0;
        for (int i = 0; i < 5; i++) ar_send(IdW'(i + 8), AddrW'($urandom));
        n_total++; if (axi_ar_ready !== 1'b0) $display("FAIL full_ar_ready: got %b, required 0", axi_ar_ready); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            wait_r(ok);
            if (ok) begin
                ei = exp_id.pop_front();
                ea = exp_addr.pop_front();
                n_total++; if (axi_r_id !== ei) $display("FAIL full_r_id%0d: got %0d, required %0d", i, axi_r_id, ei); else n_pass++;
                n_total++; if (axi_r_data !== exp_vec(ea)) $display("FAIL full_r_data%0d: got %h, required %h", i, axi_r_data, exp_vec(ea)); else n_pass++;
                repeat ($urandom_range(0, 2)) tick();
                r_accept();
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int unsigned bad;
        logic [IdW-1:0]   ei;
        logic [AddrW-1:0] ea;
        for (int t = 0; t < 3; t++) begin
            rdy_mode = (t == 1) ? 2 : 1;
            lat_max  = 3;
            req_log.delete();
            ar_send(IdW'($urandom), AddrW'($urandom));
            wait_r(ok);
            if (ok) begin
                ei = exp_id.pop_front();
                ea = exp_addr.pop_front();
                bad = 0;
                for (int c = 0; c < 10; c++) begin
                    if (axi_r_valid !== 1'b1 || axi_r_id !== ei || axi_r_data !== exp_vec(ea)) bad++;
                    tick();
                end
                n_total++; if (bad != 0) $display("FAIL stall_hold%0d: %0d bad cycles, required 0", t, bad); else n_pass++;
                r_accept();
                n_total++; if (req_log.size() != Beats) $display("FAIL stall_beats%0d: got %0d reads, required %0d", t, req_log.size(), Beats); else n_pass++;
            end
        end
        rdy_mode = 0;
        lat_max  = 1;
    endtask

    task automatic test_random();
        bit ok;
        int unsigned n;
        logic [IdW-1:0]   ei;
        logic [AddrW-1:0] ea;
        rdy_mode = 2;
        lat_max  = 4;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < int'(n); i++) ar_send(IdW'($urandom), AddrW'($urandom));
            for (int i = 0; i < int'(n); i++) begin
                wait_r(ok);
                if (ok) begin
                    ei = exp_id.pop_front();
                    ea = exp_addr.pop_front();
                    n_total++; if (axi_r_id !== ei) $display("FAIL rand_r_id%0d_%0d: got %0d, required %0d", r, i, axi_r_id, ei); else n_pass++;
                    n_total++; if (axi_r_data !== exp_vec(ea)) $display("FAIL rand_r_data%0d_%0d: got %h, required %h", r, i, axi_r_data, exp_vec(ea)); else n_pass++;
                    repeat ($urandom_range(0, 3)) tick();
                    r_accept();
                end
            end
        end
        rdy_mode = 0;
        lat_max  = 1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int unsigned seen = 0;
        int unsigned n = 0;
        logic [IdW-1:0]   ei;
        logic [AddrW-1:0] ea;
        rdy_mode = 0;
        lat_max  = 1;
        ar_send(4'd5, 32'h3000);
        while (seen < 2 && n < 100) begin
            tick();
            n++;
            if (mem_rsp_valid) seen++;
        end
        rstn = 1'b0;
        tick();
        exp_id.delete();
        exp_addr.delete();
        n_total++; if (axi_ar_ready !== 1'b1) $display("FAIL mid_ar_ready: got %b, required 1", axi_ar_ready); else n_pass++;
        n_total++; if (axi_r_valid !== 1'b0 || axi_r_id !== '0) $display("FAIL mid_r: valid=%b id=%h, required 0/0", axi_r_valid, axi_r_id); else n_pass++;
        n_total++; if (axi_r_data !== '0) $display("FAIL mid_r_data: got %h, required 0", axi_r_data); else n_pass++;
        n_total++; if (mem_req_valid !== 1'b0 || mem_req_addr !== '0) $display("FAIL mid_mem: valid=%b addr=%h, required 0/0", mem_req_valid, mem_req_addr); else n_pass++;
        rstn = 1'b1;
        pend_data.push_back(64'hDEAD_BEEF_DEAD_BEEF);
        pend_due.push_back(0);
        pend_data.push_back(64'hBAD0_BAD0_BAD0_BAD0);
        pend_due.push_back(0);
        n = 0;
        while ((pend_data.size() > 0 || mem_rsp_valid) && n < 100) begin
            tick();
            n++;
        end
        tick();
        n_total++; if (axi_r_valid !== 1'b0 || mem_req_valid !== 1'b0) $display("FAIL mid_stray: r_valid=%b mem_req_valid=%b, required 0/0", axi_r_valid, mem_req_valid); else n_pass++;
        ar_send(IdW'($urandom), 32'h2000);
        wait_r(ok);
        if (ok) begin
            ei = exp_id.pop_front();
            ea = exp_addr.pop_front();
            n_total++; if (axi_r_id !== ei) $display("FAIL mid_new_id: got %0d, required %0d", axi_r_id, ei); else n_pass++;
            n_total++; if (axi_r_data !== exp_vec(ea)) $display("FAIL mid_new_data: got %h, required %h", axi_r_data, exp_vec(ea)); else n_pass++;
            r_accept();
        end
    endtask

`ifdef XADAC_VLOAD_MEM_OVERLAP_EN
    task automatic test_overlap();
        bit ok;
        bit hit = 1'b0;
        logic [IdW-1:0]   ei;
        logic [AddrW-1:0] ea;
        axi_r_ready = 1'b0;
        ar_send(IdW'($urandom), AddrW'($urandom));
        ar_send(IdW'($urandom), AddrW'($urandom));
        wait_r(ok);
        for (int c = 0; c < 8 && !hit; c++) begin
            if (mem_req_valid && axi_r_valid) hit = 1'b1;
            else tick();
        end
        n_total++; if (hit !== 1'b1) $display("FAIL overlap_req_during_r: got %b, required 1", hit); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            wait_r(ok);
            if (ok) begin
                ei = exp_id.pop_front();
                ea = exp_addr.pop_front();
                n_total++; if (axi_r_id !== ei) $display("FAIL overlap_r_id%0d: got %0d, required %0d", i, axi_r_id, ei); else n_pass++;
                n_total++; if (axi_r_data !== exp_vec(ea)) $display("FAIL overlap_r_data%0d: got %h, required %h", i, axi_r_data, exp_vec(ea)); else n_pass++;
                r_accept();
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_load();
        test_unaligned();
        test_back_to_back();
        test_fifo_full();
        test_stall();
        test_random();
        test_reset_mid();
`ifdef XADAC_VLOAD_MEM_OVERLAP_EN
        test_overlap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
